// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - in-order FIFO of GRF/DM commits drained over a valid/ready handshake
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          grf_we,
    input  logic [31:0]   grf_pc,
    input  logic [4:0]    grf_a3,
    input  logic [31:0]   grf_wd,
    input  logic          dm_we,
    input  logic [31:0]   dm_pc,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_type,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_addr,
    output logic [31:0]   out_data,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic          type_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count_q;
    logic          overflow_q;

    logic          grf_req;
    logic          dm_req;
    logic          pop;
    logic [AW+1:0] free;
    logic          push_grf;
    logic          push_dm;
    logic          drop;
    logic [1:0]    n_push;
    logic [AW-1:0] tail_p1;
    logic [AW-1:0] dm_slot;

    assign grf_req = grf_we && (grf_a3 != 5'd0);
    assign dm_req  = dm_we;
    assign pop     = out_valid && out_ready;

    // A same-cycle pop releases its slot to this cycle's push.
    assign free = DEPTH_W - {1'b0, count_q} + {{(AW+1){1'b0}}, pop};

    always_comb begin
        push_grf = 1'b0;
        push_dm  = 1'b0;
        if (grf_req && (free >= (AW+2)'(1))) begin
            push_grf = 1'b1;
        end
        if (dm_req) begin
            if (grf_req) begin
                push_dm = (free >= (AW+2)'(2));
            end else begin
                push_dm = (free >= (AW+2)'(1));
            end
        end
    end

    assign drop    = (grf_req && !push_grf) || (dm_req && !push_dm);
    assign n_push  = {1'b0, push_grf} + {1'b0, push_dm};
    assign tail_p1 = tail + {{(AW-1){1'b0}}, 1'b1};
    assign dm_slot = push_grf ? tail_p1 : tail;

    // GRF always takes the older slot when both commit in one cycle.
    always_ff @(posedge clk) begin
        if (push_grf) begin
            type_mem[tail] <= 1'b0;
            pc_mem[tail]   <= grf_pc;
            addr_mem[tail] <= {27'b0, grf_a3};
            data_mem[tail] <= grf_wd;
        end
        if (push_dm) begin
            type_mem[dm_slot] <= 1'b1;
            pc_mem[dm_slot]   <= dm_pc;
            addr_mem[dm_slot] <= dm_addr;
            data_mem[dm_slot] <= dm_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + {{(AW-1){1'b0}}, 1'b1};
            end
            tail    <= tail + {{(AW-2){1'b0}}, n_push};
            count_q <= count_q + {{(AW-1){1'b0}}, n_push} - {{AW{1'b0}}, pop};
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Fields are forced to zero when empty so reset leaves them at 0 regardless of storage.
    assign out_valid = (count_q != '0);
    assign out_type  = out_valid ? type_mem[head] : 1'b0;
    assign out_pc    = out_valid ? pc_mem[head]   : 32'd0;
    assign out_addr  = out_valid ? addr_mem[head] : 32'd0;
    assign out_data  = out_valid ? data_mem[head] : 32'd0;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
